pwm_timer_mc: RTL and testbench

//  Multi-channel PWM timer: one shared counter with prescaler, NCH compare channels, three counting modes.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_cmp_ch.sv | 74 +++++++
 rtl/pwm_timer_mc.sv | 167 ++++++++++++++++
 tb/tb_pwm_timer_mc.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// ============================================================================
// Module  : pwm_pkg
// Brief   : Shared types and reset constants for the pwm_timer_mc timer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  typedef enum logic [1:0] {
    EDGE_UP  = 2'd0,
    EDGE_DN  = 2'd1,
    CENTER   = 2'd2,
    MODE_RSV = 2'd3
  } mode_t;

  localparam mode_t      MODE_RST   = EDGE_UP;
  localparam logic [7:0] DT_CNT_RST = 8'hFF;

  // The reserved encoding behaves as up-counting.
  function automatic mode_t eff_mode(input mode_t m);
    return (m == MODE_RSV) ? EDGE_UP : m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_cmp_ch.sv
// ============================================================================
// Module  : pwm_cmp_ch
// Brief   : One compare channel: shadow/active CCR, compare, polarity and the
//           optional dead-time generator (enabled by PWM_DEADTIME_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_cmp_ch
  import pwm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_upd,
  input  logic [W-1:0] i_ccr,
  input  logic [W-1:0] i_cnt_nxt,
  input  logic         i_pol,
`ifdef PWM_DEADTIME_EN
  input  logic [7:0]   i_dt,
  output logic         o_wave_n,
`endif
  output logic         o_wave
);

  logic [W-1:0] r_ccr_sh;
  logic [W-1:0] r_ccr_act;
  logic         r_act;
  logic [W-1:0] w_ccr_nxt;
  logic         w_act_nxt;

  // Compare against the counter and CCR the next cycle will show.
  assign w_ccr_nxt = i_upd ? r_ccr_sh : r_ccr_act;
  assign w_act_nxt = (i_cnt_nxt < w_ccr_nxt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ccr_sh  <= '0;
      r_ccr_act <= '0;
      r_act     <= 1'b0;
    end else begin
      if (i_load) r_ccr_sh <= i_ccr;
      if (i_upd)  r_ccr_act <= r_ccr_sh;
      r_act <= w_act_nxt;
    end
  end

`ifdef PWM_DEADTIME_EN
  logic [7:0] r_dtc;
  logic       w_dt_ok;

  // Clocks since the last compare transition, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dtc <= DT_CNT_RST;
    end else if (w_act_nxt != r_act) begin
      r_dtc <= 8'd0;
    end else if (r_dtc != 8'hFF) begin
      r_dtc <= r_dtc + 8'd1;
    end
  end

  assign w_dt_ok  = (r_dtc >= i_dt);
  assign o_wave   = (r_act & w_dt_ok) ^ i_pol;
  assign o_wave_n = (~r_act & w_dt_ok) ^ i_pol;
`else
  assign o_wave = r_act ^ i_pol;
`endif

endmodule

`default_nettype wire

// File: rtl/pwm_timer_mc.sv
// ============================================================================
// Module  : pwm_timer_mc
// Brief   : Multi-channel PWM timer with prescaler, three counting modes and
//           shadowed configuration. Optional dead-time via PWM_DEADTIME_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_timer_mc
  import pwm_pkg::*;
#(
  parameter int W   = 16,
  parameter int NCH = 4,
  parameter int PW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode_i,
  input  logic [W-1:0]     arr_i,
  input  logic [PW-1:0]    psc_i,
  input  logic [NCH*W-1:0] ccr_i,
  input  logic [NCH-1:0]   pol_i,
  input  logic             load,
  input  logic             ug,
`ifdef PWM_DEADTIME_EN
  input  logic [7:0]       dt_i,
  output logic [NCH-1:0]   wave_n,
`endif
  output logic [NCH-1:0]   wave,
  output logic [W-1:0]     cnt,
  output logic             dir,
  output logic             upd_evt
);

  localparam logic [W-1:0] c_one = W'(1);

  mode_t         r_mode_sh, r_mode_act;
  logic [W-1:0]  r_arr_sh, r_arr_act, r_cnt;
  logic [PW-1:0] r_psc_sh, r_psc_act, r_psc_cnt;
  logic          r_dir, r_upd;

  mode_t         w_mode, w_mode_new;
  logic          w_tick, w_wrap, w_upd;
  logic [W-1:0]  w_cnt_step, w_cnt_nxt;
  logic          w_dir_step, w_dir_nxt;

  assign w_mode     = eff_mode(r_mode_act);
  assign w_mode_new = eff_mode(r_mode_sh);
  assign w_tick     = en && (r_psc_cnt == r_psc_act);
  assign w_upd      = ug || (w_tick && w_wrap);

  always_comb begin
    w_cnt_step = r_cnt;
    w_dir_step = r_dir;
    w_wrap     = 1'b0;
    case (w_mode)
      EDGE_DN: begin
        w_dir_step = 1'b0;
        if (r_cnt == '0) begin
          w_cnt_step = r_arr_act;
          w_wrap     = 1'b1;
        end else begin
          w_cnt_step = r_cnt - c_one;
        end
      end
      CENTER: begin
        // Update leaves the bottom; with ARR=0 every tick is an update.
        w_wrap = (r_cnt == '0) && (r_dir || (r_arr_act == '0));
        if (r_dir) begin
          if (r_cnt >= r_arr_act) w_dir_step = 1'b0;
          else                    w_cnt_step = r_cnt + c_one;
        end else begin
          if (r_cnt == '0) w_dir_step = 1'b1;
          else             w_cnt_step = r_cnt - c_one;
        end
      end
      default: begin
        w_dir_step = 1'b1;
        if (r_cnt >= r_arr_act) begin
          w_cnt_step = '0;
          w_wrap     = 1'b1;
        end else begin
          w_cnt_step = r_cnt + c_one;
        end
      end
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_dir_nxt = r_dir;
    if (ug) begin
      w_cnt_nxt = (w_mode_new == EDGE_DN) ? r_arr_sh : '0;
      w_dir_nxt = 1'b1;
    end else if (w_tick) begin
      w_cnt_nxt = w_cnt_step;
      w_dir_nxt = w_dir_step;
      if (w_wrap && (w_mode_new != w_mode)) w_dir_nxt = (w_mode_new != EDGE_DN);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_psc_cnt <= '0;
    end else if (ug || w_tick) begin
      r_psc_cnt <= '0;
    end else if (en) begin
      r_psc_cnt <= r_psc_cnt + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= '0;
      r_dir      <= 1'b1;
      r_upd      <= 1'b0;
      r_mode_sh  <= MODE_RST;
      r_mode_act <= MODE_RST;
      r_arr_sh   <= '1;
      r_arr_act  <= '1;
      r_psc_sh   <= '0;
      r_psc_act  <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
      r_upd <= w_upd;
      if (load) begin
        r_mode_sh <= mode_t'(mode_i);
        r_arr_sh  <= arr_i;
        r_psc_sh  <= psc_i;
      end
      // Old shadow contents win when load coincides with the transfer.
      if (w_upd) begin
        r_mode_act <= r_mode_sh;
        r_arr_act  <= r_arr_sh;
        r_psc_act  <= r_psc_sh;
      end
    end
  end

  assign cnt     = r_cnt;
  assign dir     = r_dir;
  assign upd_evt = r_upd;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    pwm_cmp_ch #(
      .W(W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_load   (load),
      .i_upd    (w_upd),
      .i_ccr    (ccr_i[i*W +: W]),
      .i_cnt_nxt(w_cnt_nxt),
      .i_pol    (pol_i[i]),
`ifdef PWM_DEADTIME_EN
      .i_dt     (dt_i),
      .o_wave_n (wave_n[i]),
`endif
      .o_wave   (wave[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_pwm_timer_mc.sv
// ============================================================================
// Module  : tb_pwm_timer_mc
// Brief   : Scoreboard bench for pwm_timer_mc with directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_timer_mc;

  localparam int W   = 16;
  localparam int NCH = 4;
  localparam int PW  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode_i;
  logic [W-1:0]     arr_i;
  logic [PW-1:0]    psc_i;
  logic [NCH*W-1:0] ccr_i;
  logic [NCH-1:0]   pol_i;
  logic             load;
  logic             ug;
  logic [NCH-1:0]   wave;
  logic [W-1:0]     cnt;
  logic             dir;
  logic             upd_evt;
`ifdef PWM_DEADTIME_EN
  logic [7:0]       dt_i = 8'd0;
  logic [NCH-1:0]   wave_n;
`endif

  pwm_timer_mc #(.W(W), .NCH(NCH), .PW(PW)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode_i (mode_i),
    .arr_i  (arr_i),
    .psc_i  (psc_i),
    .ccr_i  (ccr_i),
    .pol_i  (pol_i),
    .load   (load),
    .ug     (ug),
`ifdef PWM_DEADTIME_EN
    .dt_i   (dt_i),
    .wave_n (wave_n),
`endif
    .wave   (wave),
    .cnt    (cnt),
    .dir    (dir),
    .upd_evt(upd_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   cnt;
    logic [NCH-1:0] wave;
    logic           dir;
    logic           upd;
    string          tag;
  } exp_t;

  exp_t           q[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [W-1:0]   e_ccr[NCH];
  logic [NCH-1:0] s_pol;

  function automatic logic [NCH-1:0] exp_wave(input logic [W-1:0] c);
    logic [NCH-1:0] r;
    for (int i = 0; i < NCH; i++) r[i] = (c < e_ccr[i]) ^ pol_i[i];
    return r;
  endfunction

  task automatic cyc(input logic e, input logic l, input logic u,
                     input logic [W-1:0] c, input logic d, input logic up,
                     input string tag);
    exp_t x;
    @(negedge clk);
    en    = e;
    load  = l;
    ug    = u;
    pol_i = s_pol;
    x.cnt  = c;
    x.wave = exp_wave(c);
    x.dir  = d;
    x.upd  = up;
    x.tag  = tag;
    q.push_back(x);
  endtask

  task automatic set_ccr_exp(input logic live);
    e_ccr[0] = live ? 16'd3  : 16'd0;
    e_ccr[1] = live ? 16'd2  : 16'd0;
    e_ccr[2] = 16'd0;
    e_ccr[3] = live ? 16'd20 : 16'd0;
  endtask

  // Monitor: compares every DUT output sample against the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if ({cnt, wave, dir, upd_evt} !== {e.cnt, e.wave, e.dir, e.upd}) begin
        n_fail++;
        $display("FAIL %s: got cnt=%0d wave=%b dir=%b upd=%b, expected cnt=%0d wave=%b dir=%b upd=%b",
                 e.tag, cnt, wave, dir, upd_evt, e.cnt, e.wave, e.dir, e.upd);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int p, n;
    rst = 1'b1; en = 1'b0; load = 1'b0; ug = 1'b0;
    mode_i = 2'd0; arr_i = '0; psc_i = '0; ccr_i = '0; pol_i = '0;
    s_pol = '0;
    set_ccr_exp(1'b0);

    cyc(0, 0, 0, 0, 1, 0, "reset");
    cyc(0, 0, 0, 0, 1, 0, "reset");
    rst = 1'b0;

    // EDGE_UP, ARR=9; CCR = {20,0,2,3}
    mode_i = 2'd0; arr_i = 16'd9; psc_i = 8'd0;
    ccr_i  = {16'd20, 16'd0, 16'd2, 16'd3};
    cyc(0, 1, 0, 0, 1, 0, "load_up");
    set_ccr_exp(1'b1);
    cyc(0, 0, 1, 0, 1, 1, "ug_up");
    for (int k = 1; k <= 32; k++) begin
      s_pol = (k >= 21 && k <= 25) ? 4'hF : 4'h0;
      cyc(1, 0, 0, W'(k % 10), 1, (k % 10) == 0, (k >= 21 && k <= 25) ? "pol_inv" : "edge_up");
    end
    // Mid-period load of ARR=19 waits for the next update.
    arr_i = 16'd19;
    cyc(1, 1, 0, 3, 1, 0, "load_mid");
    for (int k = 34; k <= 40; k++) cyc(1, 0, 0, W'(k % 10), 1, k == 40, "old_period");
    for (int k = 41; k <= 59; k++) cyc(1, 0, 0, W'(k - 40), 1, 0, "new_period");
    // Load in the update cycle: transfer still uses ARR=19.
    arr_i = 16'd4;
    cyc(1, 1, 0, 0, 1, 1, "load_upd_same");
    for (int k = 61; k <= 80; k++) cyc(1, 0, 0, W'((k - 60) % 20), 1, k == 80, "deferred");
    for (int k = 81; k <= 87; k++) cyc(1, 0, 0, W'((k - 80) % 5), 1, ((k - 80) % 5) == 0, "arr4");
    cyc(1, 0, 1, 0, 1, 1, "ug_mid");
    for (int j = 1; j <= 7; j++) cyc(1, 0, 0, W'(j % 5), 1, (j % 5) == 0, "after_ug");

    // CENTER, ARR=4
    mode_i = 2'd2; arr_i = 16'd4;
    cyc(0, 1, 0, 2, 1, 0, "load_ctr");
    cyc(0, 0, 1, 0, 1, 1, "ug_ctr");
    for (int j = 1; j <= 22; j++) begin
      p = j % 10;
      cyc(1, 0, 0, W'((p <= 4) ? p : 9 - p), p <= 4, p == 1, "center");
    end

    // EDGE_DN, ARR=5, PSC=2 with an enable freeze
    mode_i = 2'd1; arr_i = 16'd5; psc_i = 8'd2;
    cyc(0, 1, 0, 2, 1, 0, "load_dn");
    cyc(0, 0, 1, 5, 1, 1, "ug_dn");
    for (int c = 1; c <= 20; c++) begin
      n = c / 3;
      cyc(1, 0, 0, W'(5 - (n % 6)), n == 0, (c % 3 == 0) && (n % 6 == 0), "edge_dn_psc");
    end
    for (int f = 0; f < 4; f++) cyc(0, 0, 0, 5, 0, 0, "freeze");
    for (int c = 21; c <= 26; c++) begin
      n = c / 3;
      cyc(1, 0, 0, W'(5 - (n % 6)), 0, (c % 3 == 0) && (n % 6 == 0), "edge_dn_resume");
    end
    s_pol = 4'b0101;
    cyc(1, 0, 0, 2, 0, 0, "dn_pol");

    // Asynchronous reset between clock edges
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({cnt, wave, dir, upd_evt} !== {16'd0, 4'b0101, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_rst: got cnt=%0d wave=%b dir=%b upd=%b, expected cnt=0 wave=0101 dir=1 upd=0",
               cnt, wave, dir, upd_evt);
    end
    set_ccr_exp(1'b0);
    cyc(1, 0, 0, 0, 1, 0, "in_reset");
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) cyc(1, 0, 0, W'(c), 1, 0, "resume");

    // CENTER with ARR=0: dir toggles and every tick updates
    s_pol = 4'b0000;
    mode_i = 2'd2; arr_i = 16'd0; psc_i = 8'd0;
    cyc(0, 1, 0, 5, 1, 0, "load_arr0");
    set_ccr_exp(1'b1);
    cyc(0, 0, 1, 0, 1, 1, "ug_arr0");
    for (int j = 1; j <= 6; j++) cyc(1, 0, 0, 0, (j % 2) == 0, 1, "arr0");
    cyc(0, 0, 0, 0, 1, 0, "arr0_hold");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
